// File: rtl/clock_advance_sched.sv
// clock_advance_sched
//   Shares one cycle-advance engine among NUM_REQ requesters. Each grant
//   drives clk_en high for exactly the requested number of cycles, then
//   pulses done for the grantee. Arbitration is round-robin. It is decided
//   only in IDLE, and a grant is never preempted.
//
// Ports
//   clock        : free-running scheduler clock (posedge)
//   reset_n      : synchronous active-low reset
//   req          : per-requester level request
//   req_cycles   : packed cycle counts, slice i = [i*CNT_W +: CNT_W]
//   gnt          : one-hot grant, high in ADVANCE and DONE
//   done         : one-cycle completion pulse to the grantee
//   clk_en       : clock-enable to the clock generator, high only in ADVANCE
//   busy         : high whenever the scheduler is not idle
//   active_id    : index of the current or most recent grantee
//   remaining    : cycles left in the current advance
//   total_cycles : running count of ADVANCE cycles, modulo 2^64
module clock_advance_sched #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 32,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*CNT_W-1:0] req_cycles,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       done,
    output logic                     clk_en,
    output logic                     busy,
    output logic [ID_W-1:0]          active_id,
    output logic [CNT_W-1:0]         remaining,
    output logic [63:0]              total_cycles
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADVANCE,
        ST_DONE
    } state_t;

    state_t            state;
    logic [ID_W-1:0]   rr_ptr;

    logic              pick_valid;
    logic [ID_W-1:0]   pick_id;
    logic [CNT_W-1:0]  pick_cycles;
    logic [ID_W-1:0]   next_ptr;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [ID_W-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Round-robin pick: scan from the farthest candidate back toward rr_ptr
    // so the candidate closest to rr_ptr (in wrap order) is written last.
    always_comb begin
        pick_valid  = 1'b0;
        pick_id     = '0;
        pick_cycles = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[(int'(rr_ptr) + k) % NUM_REQ]) begin
                pick_valid  = 1'b1;
                pick_id     = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
                pick_cycles = req_cycles[((int'(rr_ptr) + k) % NUM_REQ) * CNT_W +: CNT_W];
            end
        end
    end

    assign next_ptr = (active_id == ID_W'(NUM_REQ - 1)) ? '0 : active_id + 1'b1;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            rr_ptr       <= '0;
            gnt          <= '0;
            done         <= '0;
            clk_en       <= 1'b0;
            busy         <= 1'b0;
            active_id    <= '0;
            remaining    <= '0;
            total_cycles <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        active_id <= pick_id;
                        remaining <= pick_cycles;
                        gnt       <= onehot(pick_id);
                        busy      <= 1'b1;
                        // A zero count goes straight to DONE, so done
                        // accompanies gnt in the very first granted cycle.
                        if (pick_cycles != '0) begin
                            state  <= ST_ADVANCE;
                            clk_en <= 1'b1;
                            done   <= '0;
                        end else begin
                            state  <= ST_DONE;
                            clk_en <= 1'b0;
                            done   <= onehot(pick_id);
                        end
                    end else begin
                        gnt    <= '0;
                        done   <= '0;
                        clk_en <= 1'b0;
                        busy   <= 1'b0;
                    end
                end

                ST_ADVANCE: begin
                    total_cycles <= total_cycles + 64'd1;
                    remaining    <= remaining - 1'b1;
                    // remaining == 1 marks the last enabled cycle.
                    if (remaining == CNT_W'(1)) begin
                        state  <= ST_DONE;
                        clk_en <= 1'b0;
                        done   <= onehot(active_id);
                    end
                end

                ST_DONE: begin
                    state  <= ST_IDLE;
                    rr_ptr <= next_ptr;
                    gnt    <= '0;
                    done   <= '0;
                    busy   <= 1'b0;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clock_advance_sched.sv
// Testbench for clock_advance_sched.
//   A cycle-offset reference model (grant time, requested count, elapsed
//   cycles) predicts every output each cycle. Directed table vectors and
//   hand-written sequences cover the multi-cycle corner cases. A randomized
//   phase with random requests, counts and resets follows them.
module tb_clock_advance_sched;

    localparam int NR = 4;
    localparam int CW = 32;
    localparam int IW = 2;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic [NR-1:0]     req = '0;
    logic [NR*CW-1:0]  req_cycles = '0;
    logic [NR-1:0]     gnt;
    logic [NR-1:0]     done;
    logic              clk_en;
    logic              busy;
    logic [IW-1:0]     active_id;
    logic [CW-1:0]     remaining;
    logic [63:0]       total_cycles;

    clock_advance_sched #(.NUM_REQ(NR), .CNT_W(CW)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .req          (req),
        .req_cycles   (req_cycles),
        .gnt          (gnt),
        .done         (done),
        .clk_en       (clk_en),
        .busy         (busy),
        .active_id    (active_id),
        .remaining    (remaining),
        .total_cycles (total_cycles)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk      = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // t counts cycles since the grant edge (t=1 is the first granted cycle).
    // Cycles t=1..n are enabled; cycle t=n+1 is the completion cycle.
    typedef struct packed {
        logic          active;
        logic [IW-1:0] id;
        logic [31:0]   n;
        logic [31:0]   t;
        logic [IW-1:0] ptr;
        logic [IW-1:0] last;
        logic [63:0]   total;
    } model_t;

    model_t m = '0;

    function automatic model_t step(model_t cur, logic rn, logic [NR-1:0] r, logic [NR*CW-1:0] rc);
        model_t x;
        x = cur;
        if (!rn) begin
            x = '0;
        end else if (cur.active) begin
            if (cur.t <= cur.n) x.total = cur.total + 64'd1;
            if (cur.t == cur.n + 32'd1) begin
                x.active = 1'b0;
                x.ptr    = IW'((int'(cur.id) + 1) % NR);
            end else begin
                x.t = cur.t + 32'd1;
            end
        end else begin
            for (int k = 0; k < NR; k++) begin
                int j;
                j = (int'(cur.ptr) + k) % NR;
                if (r[j]) begin
                    x.active = 1'b1;
                    x.id     = IW'(j);
                    x.last   = IW'(j);
                    x.n      = rc[j*CW +: CW];
                    x.t      = 32'd1;
                    break;
                end
            end
        end
        return x;
    endfunction

    always @(posedge clock) m <= step(m, reset_n, req, req_cycles);

    always @(negedge clock) begin
        if (chk) begin
            logic [NR-1:0] eg, ed;
            logic          een;
            logic [CW-1:0] erem;
            eg = '0; ed = '0; een = 1'b0; erem = '0;
            if (m.active) begin
                eg[m.id] = 1'b1;
                if (m.t <= m.n) begin
                    een  = 1'b1;
                    erem = m.n - (m.t - 32'd1);
                end else begin
                    ed[m.id] = 1'b1;
                end
            end
            check("sb_gnt", 64'(gnt), 64'(eg));
            check("sb_done", 64'(done), 64'(ed));
            check("sb_clk_en", 64'(clk_en), 64'(een));
            check("sb_busy", 64'(busy), 64'(m.active));
            check("sb_active_id", 64'(active_id), 64'(m.last));
            check("sb_remaining", 64'(remaining), 64'(erem));
            check("sb_total", total_cycles, m.total);
        end
    end

    // ---------------- helpers ----------------
    task automatic pulse_reset();
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    // Waits for the next grant and its completion. Returns the grant vector,
    // the number of enabled cycles and the idle cycles seen before the grant.
    task automatic run_grant(input bit keep, output logic [NR-1:0] g, output int en, output int idle);
        int guard;
        g = '0; en = 0; idle = 0; guard = 0;
        @(negedge clock);
        while (gnt == '0 && guard < 300) begin
            idle++; guard++;
            @(negedge clock);
        end
        g = gnt;
        while (done == '0 && guard < 300) begin
            if (clk_en) en++;
            guard++;
            @(negedge clock);
        end
        if (guard >= 300) begin
            check("grant_timeout", 64'd1, 64'd0);
        end else if (!keep) begin
            req = req & ~done;
        end
    endtask

    typedef struct {
        int            id;
        int            n;
        int            exp_en;
        int            exp_lat;
        logic [NR-1:0] exp_done;
    } vec_t;

    initial begin
        vec_t          tbl[6];
        logic [NR-1:0] g;
        int            en, idle, lat, guard;
        logic [NR-1:0] dseen;
        logic [63:0]   tot0;

        tbl[0] = '{0, 5, 5, 6, 4'b0001};
        tbl[1] = '{2, 0, 0, 1, 4'b0100};
        tbl[2] = '{1, 1, 1, 2, 4'b0010};
        tbl[3] = '{3, 7, 7, 8, 4'b1000};
        tbl[4] = '{2, 3, 3, 4, 4'b0100};
        tbl[5] = '{0, 2, 2, 3, 4'b0001};

        // ---- reset state ----
        @(posedge clock);
        @(negedge clock);
        chk = 1'b1;
        check("rst_gnt", 64'(gnt), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_clk_en", 64'(clk_en), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_active_id", 64'(active_id), 64'd0);
        check("rst_remaining", 64'(remaining), 64'd0);
        check("rst_total", total_cycles, 64'd0);
        reset_n = 1'b1;
        @(negedge clock);

        // ---- table-driven single requests ----
        for (int v = 0; v < 6; v++) begin
            tot0 = total_cycles;
            req[tbl[v].id] = 1'b1;
            req_cycles[tbl[v].id*CW +: CW] = tbl[v].n;
            lat = 0; en = 0; dseen = '0; guard = 0;
            @(negedge clock);
            lat = 1;
            check("tbl_gnt_first", 64'(gnt), 64'(1 << tbl[v].id));
            // Count changes after grant must not matter.
            req_cycles[tbl[v].id*CW +: CW] = 32'd99;
            while (done == '0 && guard < 100) begin
                if (clk_en) en++;
                guard++;
                @(negedge clock);
                lat++;
            end
            dseen = done;
            req = '0;
            check("tbl_clk_en_cycles", 64'(en), 64'(tbl[v].exp_en));
            check("tbl_done_latency", 64'(lat), 64'(tbl[v].exp_lat));
            check("tbl_done_vec", 64'(dseen), 64'(tbl[v].exp_done));
            check("tbl_total_delta", total_cycles - tot0, 64'(tbl[v].exp_en));
            @(negedge clock);
            check("tbl_idle_after", 64'(busy), 64'd0);
        end

        // ---- simultaneous req[1] (N=3) and req[3] (N=2) after reset ----
        pulse_reset();
        req_cycles[1*CW +: CW] = 32'd3;
        req_cycles[3*CW +: CW] = 32'd2;
        req = 4'b1010;
        run_grant(1'b0, g, en, idle);
        check("sim_first_gnt", 64'(g), 64'b0010);
        check("sim_first_en", 64'(en), 64'd3);
        run_grant(1'b0, g, en, idle);
        check("sim_second_gnt", 64'(g), 64'b1000);
        check("sim_second_en", 64'(en), 64'd2);
        check("sim_gap", 64'(idle), 64'd1);
        check("sim_total", total_cycles, 64'd5);
        req = '0;
        @(negedge clock);

        // ---- round-robin fairness, all held high, N=1 ----
        pulse_reset();
        for (int i = 0; i < NR; i++) req_cycles[i*CW +: CW] = 32'd1;
        req = 4'b1111;
        for (int s = 0; s < 6; s++) begin
            run_grant(1'b1, g, en, idle);
            check("rr_gnt", 64'(g), 64'(1 << (s % NR)));
            check("rr_en", 64'(en), 64'd1);
            if (s > 0) check("rr_period_gap", 64'(idle), 64'd1);
        end
        req = '0;
        @(negedge clock);
        @(negedge clock);

        // ---- reset mid-advance ----
        pulse_reset();
        req_cycles[1*CW +: CW] = 32'd1;
        req = 4'b0010;
        run_grant(1'b0, g, en, idle);
        check("rma_pre_gnt", 64'(g), 64'b0010);
        req_cycles[3*CW +: CW] = 32'd10;
        req = 4'b1000;
        en = 0; guard = 0;
        while (en < 4 && guard < 50) begin
            @(negedge clock);
            if (clk_en) en++;
            guard++;
        end
        check("rma_reached_4", 64'(en), 64'd4);
        reset_n = 1'b0;
        req = '0;
        @(negedge clock);
        reset_n = 1'b1;
        check("rma_gnt", 64'(gnt), 64'd0);
        check("rma_done", 64'(done), 64'd0);
        check("rma_clk_en", 64'(clk_en), 64'd0);
        check("rma_busy", 64'(busy), 64'd0);
        check("rma_active_id", 64'(active_id), 64'd0);
        check("rma_remaining", 64'(remaining), 64'd0);
        check("rma_total", total_cycles, 64'd0);
        dseen = '0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            dseen = dseen | done;
        end
        check("rma_no_done", 64'(dseen), 64'd0);
        // A reset pointer picks 0 ahead of 2.
        req_cycles[0*CW +: CW] = 32'd1;
        req_cycles[2*CW +: CW] = 32'd1;
        req = 4'b0101;
        run_grant(1'b0, g, en, idle);
        check("rma_ptr_zero", 64'(g), 64'b0001);
        req = '0;
        @(negedge clock);

        // ---- req dropped mid-advance ----
        req_cycles[0*CW +: CW] = 32'd6;
        req = 4'b0001;
        en = 0; guard = 0;
        @(negedge clock);
        while (done == '0 && guard < 50) begin
            if (clk_en) en++;
            if (en == 2) req = '0;
            guard++;
            @(negedge clock);
        end
        check("drop_en", 64'(en), 64'd6);
        check("drop_done", 64'(done), 64'b0001);
        g = '0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            g = g | gnt;
        end
        check("drop_no_regrant", 64'(g), 64'd0);

        // ---- randomized phase, scoreboard checks every cycle ----
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (done[i]) req[i] = 1'b0;
                else if (!req[i] && $urandom_range(0, 3) == 0) req[i] = 1'b1;
                else if (req[i] && $urandom_range(0, 24) == 0) req[i] = 1'b0;
                req_cycles[i*CW +: CW] = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(10, 20))
                                                                      : 32'($urandom_range(0, 5));
            end
            reset_n = ($urandom_range(0, 199) != 0);
            @(negedge clock);
        end
        reset_n = 1'b1;
        req = '0;
        repeat (30) @(negedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
